data_island_assembler: RTL and testbench
========================================

DATA_ISLAND_ASSEMBLER -- requirements
Module: data_island_assembler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning packet FIFO depth in whole packets (legal 2..8).
REQ-002 SHALL have parameter MAX_PACKETS, default 18, meaning the maximum packets emitted per enable period (legal 1..18).
REQ-003 SHALL have port clk_pixel, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, high while the data island period is active.
REQ-006 SHALL have port in_valid, input, 1, meaning the upstream packet is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning the FIFO accepts a packet.
REQ-008 SHALL have port in_header, input, 24, HB0..HB2 (bit 0 sent first).
REQ-009 SHALL have port in_sub, input, 224, subpackets 0..3 at [56i+55:56i].
REQ-010 SHALL have port packet_data, output, 9, the per-pixel TMDS data-island symbol.
REQ-011 SHALL have port packet_enable, output, 1, high with symbol 0 of every packet.
REQ-012 SHALL have port pkt_count, output, 5, packets started in the current enable period.
REQ-013 SHALL have port island_full, output, 1, meaning pkt_count == MAX_PACKETS.
REQ-014 SHALL have port fifo_level, output, 4, FIFO occupancy 0..DEPTH.

Function
REQ-015 SHALL accept a packet on the in_valid && in_ready edge; in_ready = (fifo_level < DEPTH), with a same-cycle pop freeing no slot until the next cycle.
REQ-016 SHALL keep a 5-bit symbol counter k that advances once per enable-high cycle, wraps 31->0, and resets to 0 when enable is low.
REQ-017 SHALL start a packet at k == 0: pop the FIFO if non-empty and pkt_count < MAX_PACKETS, increment pkt_count, and serialise the packet over k = 0..31.
REQ-018 SHALL register packet_data/packet_enable: the edge where enable = 1 and the counter is k loads symbol k; outputs hold their values while enable = 0.
REQ-019 SHALL map symbol k as [0] = lane-4 bit k, [4:1] = sub0..3 bit 2k, [8:5] = sub0..3 bit 2k+1.
REQ-020 SHALL form lane 4 as {ecc4, header} (32 bits) and lane i as {ecc_i, sub_i} (64 bits).
REQ-021 SHALL compute each ECC serially from 0 per packet: per bit, ecc = (ecc >> 1) ^ ((ecc[0] ^ bit) ? 8'h83 : 8'h00), over header bits 0..23 and subpacket bits 0..55 (two per cycle, even bit first).
REQ-022 SHALL, when enable falls mid-packet, abort the packet, discard it (not re-queued), clear the ECCs, and clear pkt_count and island_full.
REQ-023 SHALL, once island_full, start no further packets: lanes emit 0 and packet_enable stays 0 until enable falls.
REQ-024 SHALL keep simultaneous push and pop at the same level; a push while full is ignored.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear packet_data = 9'h000, packet_enable = 0, pkt_count = 0, island_full = 0, fifo_level = 0, k = 0, and all ECCs.
REQ-026 SHALL make in_ready equal to 1 in the first cycle after reset_n deasserts.

Configuration
REQ-027 SHALL use macro DIA_NULL_FILL_EN: when defined, an empty FIFO at k == 0 emits a null packet (all-zero header/subpackets, zero ECC, packet_enable = 1, pkt_count increments).
REQ-028 SHALL, when DIA_NULL_FILL_EN is undefined, hold k at 0 while the FIFO is empty (packet_data = 0, packet_enable = 0) and start on the first cycle a packet is present.

Verification
REQ-029 SHALL cover: header 24'h000001, subs zero, enable high 32 cycles -> packet_data[0] bits 0..31 = 1, 0 x23, then 8'h4A LSB first (0,1,0,1,0,0,1,0); [8:1] = 0.
REQ-030 SHALL cover: push DEPTH = 4 packets with enable low -> fifo_level = 4, in_ready = 0; a 5th in_valid is ignored.
REQ-031 SHALL cover: 20 queued packets, MAX_PACKETS = 18, enable held -> 18 packet_enable pulses 32 cycles apart, island_full = 1 after pulse 18, fifo_level = 2 remains.
REQ-032 SHALL cover: enable dropped at k = 10 -> next enable period starts k = 0 with the following FIFO packet, pkt_count = 1, and correct ECC.
REQ-033 SHALL cover: FIFO empty with enable high -> with DIA_NULL_FILL_EN, packet_data = 9'h000 and packet_enable pulses every 32 cycles; without it, no pulse until push, then a pulse on the next enable-high edge.
REQ-034 SHALL cover: reset_n asserted mid-packet -> all outputs are zero immediately (asynchronous) and fifo_level = 0.

Source files
------------

// File: rtl/data_island_assembler.sv
// data_island_assembler
//   Queues complete data-island packets (24-bit header + four 56-bit
//   subpackets) in a small FIFO. It then serialises one packet every 32
//   enable-high pixel clocks into 9-bit TMDS data-island symbols. Each lane
//   carries its data followed by an 8-bit BCH ECC (poly 0x83, LSB-first),
//   computed serially while the data bits are being sent.
//
//   Optional build macro: DIA_NULL_FILL_EN
//     When defined, an empty FIFO at a packet boundary emits an all-zero
//     null packet. When undefined, the symbol counter waits at 0 until a
//     packet is queued.
//
// Ports
//   clk_pixel      in   pixel clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   enable         in   data island period active
//   in_valid       in   upstream packet valid
//   in_ready       out  FIFO can accept a packet
//   in_header      in   HB0..HB2, bit 0 sent first
//   in_sub         in   subpacket i at [56i+55:56i]
//   packet_data    out  registered 9-bit symbol
//   packet_enable  out  high with symbol 0 of each packet
//   pkt_count      out  packets started in this enable period
//   island_full    out  pkt_count == MAX_PACKETS
//   fifo_level     out  FIFO occupancy 0..DEPTH
module data_island_assembler #(
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned MAX_PACKETS = 18
) (
   input  logic         clk_pixel,
   input  logic         reset_n,
   input  logic         enable,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [23:0]  in_header,
   input  logic [223:0] in_sub,
   output logic [8:0]   packet_data,
   output logic         packet_enable,
   output logic [4:0]   pkt_count,
   output logic         island_full,
   output logic [3:0]   fifo_level
);

`ifdef DIA_NULL_FILL_EN
   localparam logic NULL_FILL = 1'b1;
`else
   localparam logic NULL_FILL = 1'b0;
`endif

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [23:0]      hdr_mem [DEPTH];
   logic [223:0]     sub_mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   logic [4:0]       k;
   logic             active;
   logic [23:0]      hdr_r;
   logic [223:0]     sub_r;
   logic [7:0]       ecc_h;
   logic [7:0]       ecc_s [4];

   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             can_start;
   logic             emit;
   logic [23:0]      start_hdr;
   logic [223:0]     start_sub;
   logic [23:0]      cur_hdr;
   logic [223:0]     cur_sub;
   logic [31:0]      hdr_ext;
   logic [63:0]      sub_ext [4];
   logic [7:0]       ecc_h_nxt;
   logic [7:0]       ecc_s_nxt [4];
   logic [8:0]       sym;

   function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic b);
      return (e >> 1) ^ (((e[0] ^ b) == 1'b1) ? 8'h83 : 8'h00);
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign island_full = (pkt_count == 5'(MAX_PACKETS));

   always_comb begin
      fifo_empty = (fifo_level == '0);
      in_ready   = (fifo_level < 4'(DEPTH));
      push       = in_valid && in_ready;
      can_start  = enable && (k == '0) && (pkt_count < 5'(MAX_PACKETS)) &&
                   (!fifo_empty || NULL_FILL);
      pop        = can_start && !fifo_empty;
      emit       = can_start || (enable && active && (k != '0));

      // Symbol 0 is built straight from the FIFO head, since the packet
      // register is only loaded on that same edge.
      start_hdr  = fifo_empty ? '0 : hdr_mem[rd_ptr];
      start_sub  = fifo_empty ? '0 : sub_mem[rd_ptr];
      cur_hdr    = (k == '0) ? start_hdr : hdr_r;
      cur_sub    = (k == '0) ? start_sub : sub_r;

      // Zero-extended so the symbol index never leaves the vector.
      hdr_ext    = {8'h00, cur_hdr};
      ecc_h_nxt  = ecc_step((k == '0) ? 8'h00 : ecc_h, hdr_ext[k]);

      sym        = '0;
      sym[0]     = (k < 5'd24) ? hdr_ext[k] : ecc_h[k[2:0]];
      for (int unsigned i = 0; i < 4; i++) begin
         sub_ext[i]   = {8'h00, cur_sub[56*i +: 56]};
         ecc_s_nxt[i] = ecc_step(ecc_step((k == '0) ? 8'h00 : ecc_s[i],
                                          sub_ext[i][{k, 1'b0}]),
                                 sub_ext[i][{k, 1'b1}]);
         sym[1+i]     = (k < 5'd28) ? sub_ext[i][{k, 1'b0}] : ecc_s[i][{k[1:0], 1'b0}];
         sym[5+i]     = (k < 5'd28) ? sub_ext[i][{k, 1'b1}] : ecc_s[i][{k[1:0], 1'b1}];
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_level <= fifo_level + 4'd1;
            2'b01:   fifo_level <= fifo_level - 4'd1;
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (push) begin
         hdr_mem[wr_ptr] <= in_header;
         sub_mem[wr_ptr] <= in_sub;
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (can_start) begin
         hdr_r <= start_hdr;
         sub_r <= start_sub;
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         k             <= '0;
         active        <= 1'b0;
         pkt_count     <= '0;
         packet_data   <= '0;
         packet_enable <= 1'b0;
         ecc_h         <= '0;
         for (int unsigned i = 0; i < 4; i++) ecc_s[i] <= '0;
      end else if (!enable) begin
         // Any packet in flight is dropped; symbol outputs keep their value.
         k         <= '0;
         active    <= 1'b0;
         pkt_count <= '0;
         ecc_h     <= '0;
         for (int unsigned i = 0; i < 4; i++) ecc_s[i] <= '0;
      end else begin
         if (can_start) pkt_count <= pkt_count + 5'd1;

         if (can_start)         active <= 1'b1;
         else if (k == 5'd31)   active <= 1'b0;

         // Without null fill the counter parks at 0 until a packet can start.
         if ((k != '0) || can_start || NULL_FILL) k <= k + 5'd1;

         if (emit) begin
            packet_data   <= sym;
            packet_enable <= can_start;
            if (k < 5'd24) ecc_h <= ecc_h_nxt;
            for (int unsigned i = 0; i < 4; i++) begin
               if (k < 5'd28) ecc_s[i] <= ecc_s_nxt[i];
            end
         end else begin
            packet_data   <= '0;
            packet_enable <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_data_island_assembler.sv
module tb_data_island_assembler;
   localparam int DEPTH = 4;
   localparam int MAXP  = 18;
`ifdef DIA_NULL_FILL_EN
   localparam bit NULLF = 1'b1;
`else
   localparam bit NULLF = 1'b0;
`endif

   logic         clk_pixel = 1'b0;
   logic         reset_n   = 1'b0;
   logic         enable    = 1'b0;
   logic         in_valid  = 1'b0;
   logic [23:0]  in_header = '0;
   logic [223:0] in_sub    = '0;
   logic         in_ready;
   logic [8:0]   packet_data;
   logic         packet_enable;
   logic [4:0]   pkt_count;
   logic         island_full;
   logic [3:0]   fifo_level;

   data_island_assembler #(.DEPTH(DEPTH), .MAX_PACKETS(MAXP)) dut (
      .clk_pixel     (clk_pixel),
      .reset_n       (reset_n),
      .enable        (enable),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_header     (in_header),
      .in_sub        (in_sub),
      .packet_data   (packet_data),
      .packet_enable (packet_enable),
      .pkt_count     (pkt_count),
      .island_full   (island_full),
      .fifo_level    (fifo_level)
   );

   always #5 clk_pixel = ~clk_pixel;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk_pixel) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [23:0]  h;
      logic [223:0] s;
   } pkt_t;

   pkt_t       mq[$];
   pkt_t       mcur   = '0;
   int         mpos   = 0;
   int         mcnt   = 0;
   bit         mact   = 1'b0;
   int         m_pre  = 0;
   bit         m_acc  = 1'b0;
   logic [8:0] m_data = '0;
   logic       m_pe   = 1'b0;

   // BCH over the first n data bits, LSB first.
   function automatic logic [7:0] bch(input logic [55:0] d, input int n);
      logic [7:0] e;
      e = 8'h00;
      for (int i = 0; i < n; i++) e = (e >> 1) ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
      return e;
   endfunction

   function automatic logic [8:0] sym_of(input pkt_t p, input int k);
      logic [31:0] l4;
      logic [63:0] ln;
      logic [8:0]  r;
      l4   = {bch({32'h0, p.h}, 24), p.h};
      r    = '0;
      r[0] = l4[k];
      for (int i = 0; i < 4; i++) begin
         ln       = {bch(p.s[56*i +: 56], 56), p.s[56*i +: 56]};
         r[1+i]   = ln[2*k];
         r[5+i]   = ln[2*k+1];
      end
      return r;
   endfunction

   always @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         mq.delete();
         mpos = 0; mcnt = 0; mact = 1'b0; m_data = '0; m_pe = 1'b0;
      end else begin
         m_pre = mq.size();
         m_acc = in_valid && (m_pre < DEPTH);
         if (!enable) begin
            mpos = 0; mcnt = 0; mact = 1'b0;
         end else if (mpos == 0) begin
            if (mcnt < MAXP && (m_pre > 0 || NULLF)) begin
               if (m_pre > 0) mcur = mq.pop_front();
               else           mcur = '0;
               mact = 1'b1; mcnt++; m_data = sym_of(mcur, 0); m_pe = 1'b1; mpos = 1;
            end else begin
               m_data = '0; m_pe = 1'b0;
            end
         end else begin
            m_data = mact ? sym_of(mcur, mpos) : 9'h000;
            m_pe   = 1'b0;
            mpos   = (mpos + 1) % 32;
            if (mpos == 0) mact = 1'b0;
         end
         if (m_acc) mq.push_back({in_header, in_sub});
      end
   end

   always @(negedge clk_pixel) begin
      if (reset_n) begin
         check("packet_data",   32'(packet_data),   32'(m_data));
         check("packet_enable", 32'(packet_enable), 32'(m_pe));
         check("pkt_count",     32'(pkt_count),     32'(mcnt));
         check("island_full",   32'(island_full),   32'(mcnt == MAXP));
         check("fifo_level",    32'(fifo_level),    32'(mq.size()));
         check("in_ready",      32'(in_ready),      32'(mq.size() < DEPTH));
      end
   end

   // ---------------- pulse monitor ----------------
   bit mon_on = 1'b0;
   int pulses[$];
   always @(negedge clk_pixel) if (mon_on && packet_enable) pulses.push_back(cyc);

   // ---------------- stimulus ----------------
   function automatic pkt_t mk(input int n);
      pkt_t p;
      p.h = 24'(32'h9E3779 * n) ^ 24'h5A0F3C;
      for (int i = 0; i < 4; i++)
         p.s[56*i +: 56] = {24'(n * 7 + i), 32'(32'h1234567 * (n + i + 1))};
      return p;
   endfunction

   task automatic push_pkt(input pkt_t p);
      int w;
      bit took;
      w = 0;
      in_header = p.h; in_sub = p.s; in_valid = 1'b1;
      do begin
         took = in_ready;
         @(negedge clk_pixel);
         w++;
      end while (!took && w < 2000);
      if (!took) begin
         n_cmp++; n_err++;
         $display("FAIL push_timeout: got in_ready 0 expected 1 within 2000 cycles");
      end
      in_valid = 1'b0;
   endtask

   logic [31:0] cap;
   logic [7:0]  hi;
   int          cnt, bad, t0;
   pkt_t        p1;

   initial begin
      repeat (3) @(negedge clk_pixel);
      check("rst_packet_data",   32'(packet_data),   32'h0);
      check("rst_packet_enable", 32'(packet_enable), 32'h0);
      check("rst_pkt_count",     32'(pkt_count),     32'h0);
      check("rst_island_full",   32'(island_full),   32'h0);
      check("rst_fifo_level",    32'(fifo_level),    32'h0);
      reset_n = 1'b1;
      @(negedge clk_pixel);
      check("in_ready_after_reset", 32'(in_ready), 32'h1);

      // Fill the FIFO with enable low, then offer a fifth packet.
      p1.h = 24'h000001; p1.s = '0;
      push_pkt(p1);
      for (int n = 2; n <= 4; n++) push_pkt(mk(n));
      check("full_level",    32'(fifo_level), 32'd4);
      check("full_in_ready", 32'(in_ready),   32'h0);
      in_header = 24'hFFFFFF; in_sub = '1; in_valid = 1'b1;
      repeat (3) @(negedge clk_pixel);
      in_valid = 1'b0;
      check("fifth_ignored", 32'(fifo_level), 32'd4);

      // Header 000001 with zero subpackets over one full packet.
      enable = 1'b1;
      cap = '0; hi = '0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk_pixel);
         if (i == 0) check("p1_pulse", 32'(packet_enable), 32'h1);
         cap[i] = packet_data[0];
         hi     = hi | packet_data[8:1];
      end
      enable = 1'b0;
      check("p1_lane4", cap, 32'h4A000001);
      check("p1_sub_lanes", 32'(hi), 32'h0);
      check("p1_count", 32'(pkt_count), 32'd1);

      // Abort a packet: enable sampled low at k = 10.
      repeat (2) @(negedge clk_pixel);
      enable = 1'b1;
      repeat (10) @(negedge clk_pixel);
      enable = 1'b0;
      repeat (3) @(negedge clk_pixel);
      check("abort_count_clear", 32'(pkt_count), 32'h0);
      enable = 1'b1;
      @(negedge clk_pixel);
      check("restart_count", 32'(pkt_count), 32'd1);
      check("restart_pulse", 32'(packet_enable), 32'h1);
      repeat (31) @(negedge clk_pixel);
      enable = 1'b0;
      check("after_abort_level", 32'(fifo_level), 32'd1);

      // FIFO runs dry with enable high.
      @(negedge clk_pixel);
      enable = 1'b1;
      repeat (32) @(negedge clk_pixel);
      cnt = 0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk_pixel);
         if (packet_enable) cnt++;
      end
      check("empty_pulses", 32'(cnt), NULLF ? 32'd2 : 32'd0);
      push_pkt(mk(5));
      @(negedge clk_pixel);
      if (!NULLF) check("late_push_pulse", 32'(packet_enable), 32'h1);
      repeat (40) @(negedge clk_pixel);
      enable = 1'b0;
      repeat (2) @(negedge clk_pixel);

      // Twenty packets against an 18-packet island limit.
      pulses.delete();
      mon_on = 1'b1;
      for (int n = 10; n < 14; n++) push_pkt(mk(n));
      check("pre_island_level", 32'(fifo_level), 32'd4);
      enable = 1'b1;
      t0 = cyc;
      for (int n = 14; n < 30; n++) push_pkt(mk(n));
      while (cyc < t0 + 18 * 32 + 40) @(negedge clk_pixel);
      mon_on = 1'b0;
      check("island_pulses", 32'(pulses.size()), 32'd18);
      bad = 0;
      for (int i = 1; i < pulses.size(); i++) if (pulses[i] - pulses[i-1] != 32) bad++;
      check("island_spacing", 32'(bad), 32'd0);
      check("island_full_flag", 32'(island_full), 32'h1);
      check("island_count", 32'(pkt_count), 32'd18);
      check("island_leftover", 32'(fifo_level), 32'd2);
      check("island_idle_data", 32'(packet_data), 32'h0);

      // Asynchronous reset in the middle of a packet.
      enable = 1'b0;
      repeat (2) @(negedge clk_pixel);
      enable = 1'b1;
      repeat (6) @(negedge clk_pixel);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_packet_data",   32'(packet_data),   32'h0);
      check("async_packet_enable", 32'(packet_enable), 32'h0);
      check("async_pkt_count",     32'(pkt_count),     32'h0);
      check("async_island_full",   32'(island_full),   32'h0);
      check("async_fifo_level",    32'(fifo_level),    32'h0);
      @(negedge clk_pixel);
      enable  = 1'b0;
      reset_n = 1'b1;
      @(negedge clk_pixel);
      check("post_reset_in_ready", 32'(in_ready), 32'h1);
      repeat (2) @(negedge clk_pixel);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
